// File: rtl/axiom_apb_pkg.sv
// Shared types and constants for the axiom APB master bridge.
// Holds the FSM state encoding plus the command/response structures.
package axiom_apb_pkg;

    localparam int unsigned APB_ADDR_WIDTH = 32;
    localparam int unsigned APB_DATA_WIDTH = 32;
    localparam int unsigned APB_STRB_WIDTH = APB_DATA_WIDTH / 8;
    localparam int unsigned APB_PROT_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic                      write;
        logic [APB_DATA_WIDTH-1:0] wdata;
        logic [APB_STRB_WIDTH-1:0] strb;
        logic [APB_PROT_WIDTH-1:0] prot;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_DATA_WIDTH-1:0] rdata;
        logic                      slverr;
    } apb_rsp_t;

endpackage

// File: rtl/axiom_apb_timeout.sv
// Wait-state counter for the APB ACCESS phase; flags expiry on the cycle
// that would be the TIMEOUT_CYCLES-th consecutive cycle with pready low.
module axiom_apb_timeout
    import axiom_apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_expired
);

    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_expired;

    // The count reflects wait cycles already elapsed, so the current tick
    // expires the transfer when it would bring the total to TIMEOUT_CYCLES.
    assign w_expired = i_tick && (r_count == LAST_COUNT);
    assign o_expired = w_expired;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_tick && !w_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/axiom_apb_master_bridge.sv
// Valid/ready command channel to APB4 master bridge, one transfer in flight.
// Optional ACCESS-phase timeout is compiled in with AXIOM_APB_TIMEOUT_EN.
module axiom_apb_master_bridge
    import axiom_apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    pclk,
    input  logic                    presetn,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic                    cmd_write,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_slverr,

    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [2:0]              pprot,
    output logic [DATA_WIDTH-1:0]   pwdata,

    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    apb_state_e r_state;
    apb_state_e w_next_state;

    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_slverr;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [STRB_WIDTH-1:0] r_pstrb;
    logic [2:0]            r_pprot;
    logic [DATA_WIDTH-1:0] r_pwdata;

    logic w_accept;
    logic w_complete;
    logic w_timeout;
    logic w_psel_next;
    logic w_penable_next;
    logic w_rsp_valid_next;
    logic w_cmd_ready_next;

    assign w_accept   = cmd_valid && r_cmd_ready;
    assign w_complete = (r_state == ACCESS) && pready;

`ifdef AXIOM_APB_TIMEOUT_EN
    logic w_timer_clear;
    logic w_timer_tick;

    assign w_timer_clear = (r_state == SETUP);
    assign w_timer_tick  = (r_state == ACCESS) && !pready;

    axiom_apb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (pclk),
        .i_rst_n   (presetn),
        .i_clear   (w_timer_clear),
        .i_tick    (w_timer_tick),
        .o_expired (w_timeout)
    );
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif

    // Outputs are computed from the next state so every one comes from a flop.
    always_comb begin
        w_next_state     = r_state;
        w_psel_next      = 1'b0;
        w_penable_next   = 1'b0;
        w_rsp_valid_next = 1'b0;
        w_cmd_ready_next = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = SETUP;
                end
            end
            SETUP: begin
                w_next_state = ACCESS;
            end
            ACCESS: begin
                if (w_complete || w_timeout) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        w_psel_next      = (w_next_state == SETUP) || (w_next_state == ACCESS);
        w_penable_next   = (w_next_state == ACCESS);
        w_rsp_valid_next = (w_next_state == RESP);
        w_cmd_ready_next = (w_next_state == IDLE);
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cmd_ready <= w_cmd_ready_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_psel      <= w_psel_next;
            r_penable   <= w_penable_next;
        end
    end

    // Reads drive no strobes and leave pwdata at the last written value.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pstrb  <= '0;
            r_pprot  <= '0;
            r_pwdata <= '0;
        end else if (w_accept) begin
            r_pwrite <= cmd_write;
            r_paddr  <= cmd_addr;
            r_pprot  <= cmd_prot;
            r_pstrb  <= cmd_write ? cmd_strb : '0;
            if (cmd_write) begin
                r_pwdata <= cmd_wdata;
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_rsp_rdata  <= '0;
            r_rsp_slverr <= 1'b0;
        end else if (w_complete) begin
            r_rsp_rdata  <= r_pwrite ? '0 : prdata;
            r_rsp_slverr <= pslverr;
        end else if (w_timeout) begin
            r_rsp_rdata  <= '0;
            r_rsp_slverr <= 1'b1;
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_slverr = r_rsp_slverr;
    assign psel       = r_psel;
    assign penable    = r_penable;
    assign pwrite     = r_pwrite;
    assign paddr      = r_paddr;
    assign pstrb      = r_pstrb;
    assign pprot      = r_pprot;
    assign pwdata     = r_pwdata;

endmodule

// File: tb/tb_axiom_apb_master_bridge.sv
// Self-checking bench for axiom_apb_master_bridge: scenario tasks plus a
// randomized run, all checked against a transfer-level reference model.
module tb_axiom_apb_master_bridge;
    import axiom_apb_pkg::*;

    localparam int TIMEOUT = 8;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int          passed = 0;
    int          total = 0;
    int          cycleCount = 0;
    logic [31:0] lastWdata = '0;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cycleCount++;

    axiom_apb_master_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_write  (cmd_write),
        .cmd_wdata  (cmd_wdata),
        .cmd_strb   (cmd_strb),
        .cmd_prot   (cmd_prot),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pstrb      (pstrb),
        .pprot      (pprot),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    task automatic waitClk();
        @(posedge pclk);
        #1;
    endtask

    // One complete transfer: drives the command and completer, checks each phase.
    task automatic runTransfer(input apb_cmd_t cmd, input int waits, input logic [31:0] rdata,
                               input logic err, input int rspDelay, input bit expectTimeout);
        logic [3:0]  expStrb;
        logic [31:0] expWdata;
        apb_rsp_t    expRsp;
        expStrb  = cmd.write ? cmd.strb : 4'h0;
        expWdata = cmd.write ? cmd.wdata : lastWdata;
        expRsp.rdata  = (expectTimeout || cmd.write) ? 32'h0 : rdata;
        expRsp.slverr = expectTimeout ? 1'b1 : err;
        if (cmd.write) lastWdata = cmd.wdata;

        total++;
        if (cmd_ready !== 1'b1) $display("[TB] FAIL idle_ready: got %b want 1", cmd_ready);
        else passed++;

        cmd_valid = 1'b1;
        cmd_addr  = cmd.addr;
        cmd_write = cmd.write;
        cmd_wdata = cmd.wdata;
        cmd_strb  = cmd.strb;
        cmd_prot  = cmd.prot;
        waitClk();
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_write = 1'($urandom);
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
        cmd_prot  = 3'($urandom);
        pready    = 1'($urandom);
        pslverr   = 1'($urandom);
        prdata    = $urandom;

        total++;
        if ({psel, penable, rsp_valid, cmd_ready} !== 4'b1000)
            $display("[TB] FAIL setup_ctrl: got %b want 1000", {psel, penable, rsp_valid, cmd_ready});
        else passed++;
        total++;
        if ({paddr, pwrite, pstrb, pprot, pwdata} !== {cmd.addr, cmd.write, expStrb, cmd.prot, expWdata})
            $display("[TB] FAIL setup_bus: got %h want %h", {paddr, pwrite, pstrb, pprot, pwdata},
                     {cmd.addr, cmd.write, expStrb, cmd.prot, expWdata});
        else passed++;
        waitClk();

        for (int k = 0; k <= waits; k++) begin
            total++;
            if ({psel, penable, rsp_valid, cmd_ready} !== 4'b1100)
                $display("[TB] FAIL access_ctrl: cycle %0d got %b want 1100", k, {psel, penable, rsp_valid, cmd_ready});
            else passed++;
            total++;
            if ({paddr, pwrite, pstrb, pprot, pwdata} !== {cmd.addr, cmd.write, expStrb, cmd.prot, expWdata})
                $display("[TB] FAIL access_bus: cycle %0d got %h want %h", k, {paddr, pwrite, pstrb, pprot, pwdata},
                         {cmd.addr, cmd.write, expStrb, cmd.prot, expWdata});
            else passed++;
            if (k < waits) begin
                pready  = 1'b0;
                pslverr = 1'($urandom);
                prdata  = $urandom;
            end else begin
                pready  = !expectTimeout;
                pslverr = expectTimeout ? 1'($urandom) : err;
                prdata  = rdata;
            end
            waitClk();
        end

        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;
        total++;
        if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0010)
            $display("[TB] FAIL resp_ctrl: got %b want 0010", {psel, penable, rsp_valid, cmd_ready});
        else passed++;
        total++;
        if ({rsp_rdata, rsp_slverr} !== expRsp)
            $display("[TB] FAIL resp_data: got %h want %h", {rsp_rdata, rsp_slverr}, expRsp);
        else passed++;

        for (int d = 0; d < rspDelay; d++) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'($urandom);
            pready    = 1'($urandom);
            prdata    = $urandom;
            waitClk();
            total++;
            if ({rsp_valid, cmd_ready, psel, rsp_rdata, rsp_slverr} !== {1'b1, 1'b0, 1'b0, expRsp})
                $display("[TB] FAIL resp_hold: wait %0d got %h want %h", d,
                         {rsp_valid, cmd_ready, psel, rsp_rdata, rsp_slverr}, {1'b1, 1'b0, 1'b0, expRsp});
            else passed++;
        end

        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        waitClk();
        rsp_ready = 1'b0;
        pready    = 1'b0;
        total++;
        if ({rsp_valid, cmd_ready, psel, penable} !== 4'b0100)
            $display("[TB] FAIL resp_done: got %b want 0100", {rsp_valid, cmd_ready, psel, penable});
        else passed++;
    endtask

    task automatic test_reset();
        presetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_write = 1'b0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        cmd_prot  = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        lastWdata = '0;
        waitClk();
        waitClk();
        total++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, psel, penable, pwrite, paddr, pstrb, pprot, pwdata} !== '0)
            $display("[TB] FAIL reset_outputs: got %h want 0",
                     {cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, psel, penable, pwrite, paddr, pstrb, pprot, pwdata});
        else passed++;
        #2 presetn = 1'b1;
        waitClk();
        total++;
        if ({cmd_ready, rsp_valid, psel, penable} !== 4'b1000)
            $display("[TB] FAIL reset_release: got %b want 1000", {cmd_ready, rsp_valid, psel, penable});
        else passed++;
    endtask

    task automatic test_write();
        apb_cmd_t c;
        c = '{addr: 32'h1000, write: 1'b1, wdata: 32'hDEADBEEF, strb: 4'hF, prot: 3'b000};
        runTransfer(c, 0, $urandom, 1'b0, 0, 1'b0);
    endtask

    task automatic test_read_wait();
        apb_cmd_t c;
        c = '{addr: 32'h2004, write: 1'b0, wdata: 32'hCAFEF00D, strb: 4'hF, prot: 3'b010};
        runTransfer(c, 3, 32'h12345678, 1'b0, 0, 1'b0);
    endtask

    task automatic test_error_backpressure();
        apb_cmd_t c;
        c = '{addr: 32'h3008, write: 1'b0, wdata: 32'h0, strb: 4'h3, prot: 3'b101};
        runTransfer(c, 1, 32'hA5A5_5A5A, 1'b1, 5, 1'b0);
        c = '{addr: 32'h300C, write: 1'b1, wdata: 32'h0BAD_F00D, strb: 4'h9, prot: 3'b111};
        runTransfer(c, 0, 32'hFFFF_FFFF, 1'b1, 5, 1'b0);
    endtask

    task automatic test_reset_mid();
        apb_cmd_t c;
        cmd_valid = 1'b1;
        cmd_addr  = 32'h4000;
        cmd_write = 1'b1;
        cmd_wdata = 32'h1357_9BDF;
        cmd_strb  = 4'hF;
        cmd_prot  = 3'b001;
        waitClk();
        cmd_valid = 1'b0;
        pready    = 1'b0;
        waitClk();
        total++;
        if ({psel, penable} !== 2'b11)
            $display("[TB] FAIL midreset_access: got %b want 11", {psel, penable});
        else passed++;
        #2 presetn = 1'b0;
        #1;
        total++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, psel, penable, pwrite, paddr, pstrb, pprot, pwdata} !== '0)
            $display("[TB] FAIL midreset_outputs: got %h want 0",
                     {cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, psel, penable, pwrite, paddr, pstrb, pprot, pwdata});
        else passed++;
        lastWdata = '0;
        waitClk();
        #2 presetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pready = 1'($urandom);
            waitClk();
            total++;
            if ({rsp_valid, psel, cmd_ready} !== 3'b001)
                $display("[TB] FAIL midreset_idle: cycle %0d got %b want 001", i, {rsp_valid, psel, cmd_ready});
            else passed++;
        end
        pready = 1'b0;
        c = '{addr: 32'h4004, write: 1'b0, wdata: 32'h0, strb: 4'hF, prot: 3'b000};
        runTransfer(c, 2, 32'h2468_ACE0, 1'b0, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        apb_cmd_t c;
        int start;
        start = cycleCount;
        for (int i = 0; i < 3; i++) begin
            c = '{addr: 32'h5000 + 32'(i * 4), write: 1'(i % 2), wdata: $urandom, strb: 4'($urandom), prot: 3'(i)};
            runTransfer(c, 0, $urandom, 1'b0, 0, 1'b0);
        end
        total++;
        if (cycleCount - start !== 12)
            $display("[TB] FAIL back_to_back_cycles: got %0d want 12", cycleCount - start);
        else passed++;
    endtask

    task automatic test_random();
        apb_cmd_t c;
        for (int i = 0; i < 20; i++) begin
            c.addr  = $urandom;
            c.write = 1'($urandom);
            c.wdata = $urandom;
            c.strb  = 4'($urandom);
            c.prot  = 3'($urandom);
            runTransfer(c, int'($urandom_range(0, 4)), $urandom, 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end
    endtask

`ifdef AXIOM_APB_TIMEOUT_EN
    task automatic test_timeout();
        apb_cmd_t c;
        c = '{addr: 32'h6000, write: 1'b0, wdata: 32'h0, strb: 4'hF, prot: 3'b000};
        runTransfer(c, TIMEOUT - 1, 32'h7777_7777, 1'b0, 2, 1'b1);
        c = '{addr: 32'h6004, write: 1'b1, wdata: 32'h8888_1111, strb: 4'hC, prot: 3'b011};
        runTransfer(c, TIMEOUT - 1, 32'h0, 1'b0, 0, 1'b1);
    endtask

    task automatic test_expiry_race();
        apb_cmd_t c;
        c = '{addr: 32'h6008, write: 1'b0, wdata: 32'h0, strb: 4'hF, prot: 3'b000};
        runTransfer(c, TIMEOUT - 1, 32'h9999_AAAA, 1'b0, 0, 1'b0);
        c = '{addr: 32'h600C, write: 1'b0, wdata: 32'h0, strb: 4'hF, prot: 3'b000};
        runTransfer(c, TIMEOUT - 1, 32'hBBBB_CCCC, 1'b1, 0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_error_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef AXIOM_APB_TIMEOUT_EN
        test_timeout();
        test_expiry_race();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
